// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard and forwarding control for the N-stage pipeline.
// Decides issue/stall at ID and registers EX forwarding selects for rs/rt.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int DEPTH    = 3,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int FLUSH_N  = 1,
  localparam int AW      = $clog2(NREG),
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            id_wr_en,
  input  logic [AW-1:0]   id_wr_reg,
  input  logic            id_is_load,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] ex_fwd_rs_sel,
  output logic [SELW-1:0] ex_fwd_rt_sel,
  output logic [31:0]     stall_cnt
);

  logic            sb_v   [1:DEPTH];
  logic [AW-1:0]   sb_reg [1:DEPTH];
  logic [SELW-1:0] sb_lat [1:DEPTH];

  logic            rs_hit, rt_hit;
  logic            rs_need, rt_need;
  logic [SELW-1:0] rs_pos, rt_pos;
  logic [SELW-1:0] rs_sel_n, rt_sel_n;
  logic            rs_look, rt_look;
  logic            issue;

  assign rs_look = id_valid & id_rs_used & (id_rs != '0);
  assign rt_look = id_valid & id_rt_used & (id_rt != '0);

  // Scan oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    rs_hit  = 1'b0;
    rs_need = 1'b0;
    rs_pos  = '0;
    rt_hit  = 1'b0;
    rt_need = 1'b0;
    rt_pos  = '0;
    for (int p = DEPTH; p >= 1; p--) begin
      if (rs_look && sb_v[p] && sb_reg[p] == id_rs) begin
        rs_hit  = 1'b1;
        rs_pos  = SELW'(p);
        rs_need = int'(sb_lat[p]) > p;
      end
      if (rt_look && sb_v[p] && sb_reg[p] == id_rt) begin
        rt_hit  = 1'b1;
        rt_pos  = SELW'(p);
        rt_need = int'(sb_lat[p]) > p;
      end
    end
  end

  assign stall = (rs_need | rt_need) & ~flush & ~reset;
  assign issue = id_valid & ~stall & ~flush;

  // A producer already at WB is visible through the write-through regfile.
  always_comb begin
    rs_sel_n = '0;
    rt_sel_n = '0;
    if (rs_hit && int'(rs_pos) < DEPTH)
      rs_sel_n = rs_pos + SELW'(1);
    if (rt_hit && int'(rt_pos) < DEPTH)
      rt_sel_n = rt_pos + SELW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 1; p <= DEPTH; p++) begin
        sb_v[p]   <= 1'b0;
        sb_reg[p] <= '0;
        sb_lat[p] <= '0;
      end
      ex_fwd_rs_sel <= '0;
      ex_fwd_rt_sel <= '0;
      stall_cnt     <= '0;
    end else begin
      // Flush kills entries that sat in 1..FLUSH_N before this shift.
      for (int p = DEPTH; p >= 2; p--) begin
        sb_v[p]   <= sb_v[p-1] & ~(flush & (p - 1 <= FLUSH_N));
        sb_reg[p] <= sb_reg[p-1];
        sb_lat[p] <= sb_lat[p-1];
      end
      sb_v[1]   <= issue & id_wr_en & (id_wr_reg != '0);
      sb_reg[1] <= id_wr_reg;
      sb_lat[1] <= id_is_load ? SELW'(LOAD_LAT) : SELW'(ALU_LAT);
      ex_fwd_rs_sel <= issue ? rs_sel_n : '0;
      ex_fwd_rt_sel <= issue ? rt_sel_n : '0;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at default parameters.
// Each task drives one scenario and checks hand-computed values inline.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_rs_used, id_rt_used;
  logic        id_wr_en;
  logic [4:0]  id_wr_reg;
  logic        id_is_load;
  logic        flush;
  logic        stall;
  logic [1:0]  ex_fwd_rs_sel, ex_fwd_rt_sel;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_used    (id_rs_used),
    .id_rt_used    (id_rt_used),
    .id_wr_en      (id_wr_en),
    .id_wr_reg     (id_wr_reg),
    .id_is_load    (id_is_load),
    .flush         (flush),
    .stall         (stall),
    .ex_fwd_rs_sel (ex_fwd_rs_sel),
    .ex_fwd_rt_sel (ex_fwd_rt_sel),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ru,
                       input logic tu, input logic we,
                       input logic [4:0] wr, input logic ld);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_rs_used = ru;
    id_rt_used = tu;
    id_wr_en   = we;
    id_wr_reg  = wr;
    id_is_load = ld;
  endtask

  task automatic alu(input logic [4:0] wr, input logic [4:0] rs,
                     input logic [4:0] rt);
    drive(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, wr, 1'b0);
  endtask

  task automatic load(input logic [4:0] wr, input logic [4:0] base);
    drive(1'b1, base, 5'd0, 1'b1, 1'b0, 1'b1, wr, 1'b1);
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    bubble();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bubble();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    checks++;
    if (ex_fwd_rs_sel !== 2'd0 || ex_fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_sel: got %0d/%0d expected 0/0",
               ex_fwd_rs_sel, ex_fwd_rt_sel);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %h expected 0", stall_cnt);
    end
  endtask

  task automatic test_alu_fwd();
    alu(5'd1, 5'd2, 5'd3);
    tick();
    alu(5'd2, 5'd1, 5'd1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall: got %b expected 0", stall);
    end
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd2 || ex_fwd_rt_sel !== 2'd2) begin
      errors++;
      $display("FAIL alu_sel: got %0d/%0d expected 2/2",
               ex_fwd_rs_sel, ex_fwd_rt_sel);
    end
    drain();
  endtask

  task automatic test_load_use();
    load(5'd1, 5'd2);
    tick();
    alu(5'd2, 5'd1, 5'd3);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b expected 1", stall);
    end
    tick();
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_release: got %b expected 0", stall);
    end
    checks++;
    if (ex_fwd_rs_sel !== 2'd0 || stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_bubble: got sel %0d cnt %0d expected 0 1",
               ex_fwd_rs_sel, stall_cnt);
    end
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd3 || ex_fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL lu_sel: got %0d/%0d expected 3/0",
               ex_fwd_rs_sel, ex_fwd_rt_sel);
    end
    drain();
  endtask

  task automatic test_distance();
    alu(5'd1, 5'd2, 5'd3);
    tick();
    bubble();
    tick();
    alu(5'd4, 5'd1, 5'd5);
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd3 || ex_fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL dist2_sel: got %0d/%0d expected 3/0",
               ex_fwd_rs_sel, ex_fwd_rt_sel);
    end
    drain();
    alu(5'd1, 5'd2, 5'd3);
    tick();
    bubble();
    tick();
    tick();
    alu(5'd4, 5'd1, 5'd5);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL dist3_stall: got %b expected 0", stall);
    end
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd0) begin
      errors++;
      $display("FAIL dist3_sel: got %0d expected 0", ex_fwd_rs_sel);
    end
    drain();
  endtask

  task automatic test_youngest();
    alu(5'd1, 5'd2, 5'd3);
    tick();
    load(5'd1, 5'd2);
    tick();
    alu(5'd6, 5'd1, 5'd7);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL young_stall: got %b expected 1", stall);
    end
    tick();
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd3) begin
      errors++;
      $display("FAIL young_sel: got %0d expected 3", ex_fwd_rs_sel);
    end
    drain();
    load(5'd0, 5'd2);
    tick();
    alu(5'd6, 5'd0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_stall: got %b expected 0", stall);
    end
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd0 || ex_fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL r0_sel: got %0d/%0d expected 0/0",
               ex_fwd_rs_sel, ex_fwd_rt_sel);
    end
    drain();
  endtask

  task automatic test_flush();
    load(5'd1, 5'd2);
    tick();
    alu(5'd2, 5'd1, 5'd3);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b expected 0", stall);
    end
    tick();
    flush = 1'b0;
    alu(5'd4, 5'd1, 5'd1);
    #1;
    checks++;
    if (ex_fwd_rs_sel !== 2'd0 || stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL flush_bubble: got sel %0d cnt %0d expected 0 2",
               ex_fwd_rs_sel, stall_cnt);
    end
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd0 || ex_fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL flush_sel: got %0d/%0d expected 0/0",
               ex_fwd_rs_sel, ex_fwd_rt_sel);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    load(5'd1, 5'd2);
    tick();
    alu(5'd2, 5'd1, 5'd3);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_stall: got %b expected 1", stall);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mask: got %b expected 0", stall);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_clear: got stall %b cnt %0d expected 0 0",
               stall, stall_cnt);
    end
    checks++;
    if (ex_fwd_rs_sel !== 2'd0 || ex_fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_sel: got %0d/%0d expected 0/0",
               ex_fwd_rs_sel, ex_fwd_rt_sel);
    end
    tick();
    bubble();
    checks++;
    if (ex_fwd_rs_sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_reissue: got %0d expected 0", ex_fwd_rs_sel);
    end
    drain();
  endtask

  task automatic test_saturation();
    dut.stall_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      load(5'd1, 5'd2);
      tick();
      alu(5'd2, 5'd1, 5'd3);
      tick();
      checks++;
      if (stall_cnt !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL sat_%0d: got %h expected ffffffff", i, stall_cnt);
      end
      tick();
      bubble();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_distance();
    test_youngest();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
